flow_arb_mux: RTL and testbench

- Parametrised successor to the flat combinational word selector in the flow-control library.
- Selects one of CHANNELS input streams, each WIDTH bits wide, and registers it onto a single output stream with valid/ready handshakes.
- Two modes: fixed-select (steered by sel) and round-robin arbitration.
- Sits between producer units and a shared consumer, e.g. a writeback or bus port.

---
 rtl/flow_pkg.sv | 7 +
 rtl/rr_pick.sv | 27 ++
 rtl/flow_arb_mux.sv | 56 +++++
 tb/tb_flow_arb_mux.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/flow_pkg.sv
// flow_pkg: shared defaults and mode encodings for the flow-control library.
package flow_pkg;
  localparam int FLOW_WIDTH_DEF = 20;
  localparam int FLOW_CH_DEF = 32;
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR = 1'b1;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: rotating-priority encoder; the search starts just after ptr and wraps modulo CHANNELS.
module rr_pick #(
  parameter int CHANNELS = 32,
  parameter int SEL_W = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SEL_W-1:0]    ptr,
  output logic [CHANNELS-1:0] gnt_onehot,
  output logic [SEL_W-1:0]    gnt_idx,
  output logic                any
);
  always_comb begin
    int j;
    j = 0;
    gnt_onehot = '0;
    gnt_idx = '0;
    any = 1'b0;
    for (int k = 1; k <= CHANNELS; k++) begin
      j = (int'(ptr) + k) % CHANNELS;
      if (!any && req[j]) begin
        any = 1'b1;
        gnt_onehot[j] = 1'b1;
        gnt_idx = SEL_W'(j);
      end
    end
  end
endmodule

// File: rtl/flow_arb_mux.sv
// flow_arb_mux: registered CHANNELS-to-1 stream mux, steered by sel or by round-robin arbitration.
module flow_arb_mux
  import flow_pkg::*;
#(
  parameter int WIDTH = FLOW_WIDTH_DEF,
  parameter int CHANNELS = FLOW_CH_DEF,
  parameter int SEL_W = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      rr_en,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_ch,
  output logic                      out_valid,
  input  logic                      out_ready
);
  logic [SEL_W-1:0] ptr_q, ptr_d, ch_q, ch_d, gnt_idx, src;
  logic [WIDTH-1:0] data_q, data_d;
  logic valid_q, valid_d, load_en, any, sel_ok, xfer;
  logic [CHANNELS-1:0] gnt_oh, fix_oh;
  rr_pick #(.CHANNELS(CHANNELS), .SEL_W(SEL_W)) u_pick (
    .req(in_valid), .ptr(ptr_q), .gnt_onehot(gnt_oh), .gnt_idx(gnt_idx), .any(any)
  );
  always_comb begin
    load_en = !valid_q || out_ready;
    sel_ok = 32'(sel) < CHANNELS;
    fix_oh = sel_ok ? CHANNELS'(1) << sel : '0;
    in_ready = (rr_en == MODE_RR ? (any ? gnt_oh : '0) : fix_oh) & {CHANNELS{load_en}};
    xfer = |(in_valid & in_ready);
    src = rr_en == MODE_FIXED ? sel : gnt_idx;
    valid_d = xfer || (valid_q && !out_ready);
    data_d = xfer ? in_data[32'(src)*WIDTH +: WIDTH] : data_q;
    ch_d = xfer ? src : ch_q;
    ptr_d = xfer && rr_en == MODE_RR ? gnt_idx : ptr_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q <= '0;
      ch_q <= '0;
      ptr_q <= SEL_W'(CHANNELS - 1);
    end else begin
      valid_q <= valid_d;
      data_q <= data_d;
      ch_q <= ch_d;
      ptr_q <= ptr_d;
    end
  end
  assign out_valid = valid_q;
  assign out_data = data_q;
  assign out_ch = ch_q;
endmodule

// File: tb/tb_flow_arb_mux.sv
// tb_flow_arb_mux: directed stimulus against a queue-free behavioural model plus literal spot checks.
module tb_flow_arb_mux;
  logic clk = 1'b0, rst = 1'b1;
  logic [32*20-1:0] in_data;
  logic [31:0] in_valid, in_ready;
  logic rr_en, out_ready, out_valid;
  logic [4:0] sel, out_ch;
  logic [19:0] out_data;
  logic [5*20-1:0] in_data5;
  logic [4:0] in_valid5, in_ready5;
  logic rr5, out_valid5;
  logic [2:0] sel5, out_ch5;
  logic [19:0] out_data5;
  int n_cmp = 0, n_bad = 0;
  bit m_v;
  logic [19:0] m_d;
  logic [4:0] m_c;
  int m_p;
  int acc[$];

  flow_arb_mux dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .rr_en(rr_en), .sel(sel), .out_data(out_data), .out_ch(out_ch),
    .out_valid(out_valid), .out_ready(out_ready)
  );
  flow_arb_mux #(.WIDTH(20), .CHANNELS(5)) dut5 (
    .clk(clk), .rst(rst), .in_data(in_data5), .in_valid(in_valid5), .in_ready(in_ready5),
    .rr_en(rr5), .sel(sel5), .out_data(out_data5), .out_ch(out_ch5),
    .out_valid(out_valid5), .out_ready(1'b1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", n, a, e, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Model: the spec rules evaluated once per cycle on the falling edge, when inputs are settled.
  always @(negedge clk) begin
    logic [31:0] exp_rdy;
    bit ld, found;
    int g;
    if (rst) begin
      m_v = 0; m_d = '0; m_c = '0; m_p = 31;
    end
    ld = !m_v || out_ready;
    exp_rdy = '0;
    found = 0;
    g = 0;
    if (!rr_en) begin
      exp_rdy[sel] = ld;
      g = int'(sel);
    end else
      for (int k = 1; k <= 32; k++)
        if (!found && in_valid[(m_p + k) % 32]) begin
          found = 1;
          g = (m_p + k) % 32;
          exp_rdy[g] = ld;
        end
    chk("m_out_valid", 64'(out_valid), 64'(m_v));
    chk("m_out_data", 64'(out_data), 64'(m_d));
    chk("m_out_ch", 64'(out_ch), 64'(m_c));
    chk("m_in_ready", 64'(in_ready), 64'(exp_rdy));
    if (out_valid && out_ready) acc.push_back(int'(out_ch));
    if (!rst) begin
      if (|(in_valid & exp_rdy)) begin
        m_v = 1;
        m_d = in_data[g*20 +: 20];
        m_c = 5'(g);
        if (rr_en) m_p = g;
      end else if (out_ready) m_v = 0;
    end
  end

  initial begin
    int seq[5];
    seq = '{0, 1, 2, 4, 31};
    rr_en = 1; in_valid = '0; out_ready = 1; sel = '0;
    for (int i = 0; i < 32; i++) in_data[i*20 +: 20] = 20'(i);
    rr5 = 1; in_valid5 = '0; sel5 = '0;
    for (int i = 0; i < 5; i++) in_data5[i*20 +: 20] = 20'(32'h100 + i);
    repeat (2) step();
    chk("rst_valid", 64'(out_valid), 0);
    chk("rst_ready", 64'(in_ready), 0);
    rst = 0;
    repeat (2) step();
    chk("idle_valid", 64'(out_valid), 0);
    chk("idle_data", 64'(out_data), 0);
    chk("idle_ch", 64'(out_ch), 0);
    chk("idle_ready", 64'(in_ready), 0);
    // Five channels: out-of-range select, then a wrapping round-robin search.
    rr5 = 0; sel5 = 3'd6; in_valid5 = '1;
    #1 chk("c5_sel6_ready", 64'(in_ready5), 0);
    step();
    chk("c5_sel6_valid", 64'(out_valid5), 0);
    rr5 = 1; in_valid5 = 5'b10000;
    step();
    chk("c5_rr_ch4", 64'(out_ch5), 4);
    chk("c5_rr_d4", 64'(out_data5), 64'h104);
    in_valid5 = 5'b00001;
    step();
    chk("c5_rr_ch0", 64'(out_ch5), 0);
    chk("c5_rr_d0", 64'(out_data5), 64'h100);
    in_valid5 = '0;
    rr_en = 0; in_valid = '1;
    foreach (seq[i]) begin
      sel = 5'(seq[i]);
      #1 chk("fix_ready", 64'(in_ready), 64'(32'd1 << seq[i]));
      step();
      chk("fix_data", 64'(out_data), 64'(seq[i]));
      chk("fix_ch", 64'(out_ch), 64'(seq[i]));
    end
    rr_en = 1;
    step();
    acc.delete();
    repeat (33) step();
    chk("rr_all_n", 64'(acc.size()), 33);
    for (int i = 0; i < 33 && i < acc.size(); i++) chk("rr_all_seq", 64'(acc[i]), 64'(i % 32));
    in_valid = (32'd1 << 3) | (32'd1 << 17);
    step();
    acc.delete();
    repeat (4) step();
    chk("rr_2_n", 64'(acc.size()), 4);
    for (int i = 0; i < 4 && i < acc.size(); i++) chk("rr_2_seq", 64'(acc[i]), (i % 2) ? 17 : 3);
    in_valid = 32'd1 << 3;
    step();
    acc.delete();
    repeat (3) step();
    chk("rr_1_n", 64'(acc.size()), 3);
    for (int i = 0; i < 3 && i < acc.size(); i++) chk("rr_1_seq", 64'(acc[i]), 3);
    rr_en = 0; in_valid = '1; sel = 5'd10;
    step();
    out_ready = 0; sel = 5'd11;
    repeat (4) begin
      step();
      chk("bp_data", 64'(out_data), 64'h0000A);
      chk("bp_valid", 64'(out_valid), 1);
      chk("bp_ready", 64'(in_ready), 0);
    end
    out_ready = 1;
    step();
    chk("bp_next_data", 64'(out_data), 11);
    chk("bp_next_valid", 64'(out_valid), 1);
    out_ready = 0;
    step();
    rst = 1;
    #1 chk("arst_valid", 64'(out_valid), 0);
    chk("arst_data", 64'(out_data), 0);
    step();
    rst = 0; rr_en = 1; in_valid = '0;
    step();
    chk("post_rst_valid", 64'(out_valid), 0);
    chk("post_rst_ready", 64'(in_ready), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
